// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: forward-select
// encodings, controller state enum and register-address match helper.
package hazard_ctrl_pkg;

    localparam int FORWARD_WIDTH = 2;

    localparam logic [FORWARD_WIDTH-1:0] FORWARD_NONE = 2'd0;
    localparam logic [FORWARD_WIDTH-1:0] FORWARD_MEM  = 2'd1;
    localparam logic [FORWARD_WIDTH-1:0] FORWARD_WB   = 2'd2;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_t;

    // x0 is hard-wired zero, so it never creates a dependency.
    function automatic logic addr_hit(input logic [4:0] rd, input logic [4:0] rs);
        return (rs != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Operand forward selection for one ID source register; a MEM-stage ALU
// result beats a WB-stage result, and a load still in MEM cannot forward.
module fwd_sel
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0]               rs_addr,
    input  logic [4:0]               mem_rd_addr,
    input  logic                     mem_reg_write,
    input  logic                     mem_mem_read,
    input  logic [4:0]               wb_rd_addr,
    input  logic                     wb_reg_write,
    output logic [FORWARD_WIDTH-1:0] fwd
);

    always_comb begin
        fwd = FORWARD_NONE;
        if (mem_reg_write && !mem_mem_read && addr_hit(mem_rd_addr, rs_addr)) begin
            fwd = FORWARD_MEM;
        end else if (wb_reg_write && addr_hit(wb_rd_addr, rs_addr)) begin
            fwd = FORWARD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use and branch
// stalls, taken-branch redirect, slow-memory freeze and perf counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     id_rs1_rd_en,
    input  logic                     id_rs2_rd_en,
    input  logic [4:0]               id_rs1_addr,
    input  logic [4:0]               id_rs2_addr,
    input  logic                     id_is_branch,
    input  logic                     id_branch_taken,
    input  logic [4:0]               ex_rd_addr,
    input  logic                     ex_reg_write,
    input  logic                     ex_mem_read,
    input  logic [4:0]               mem_rd_addr,
    input  logic                     mem_reg_write,
    input  logic                     mem_mem_read,
    input  logic                     mem_mem_write,
    input  logic [4:0]               wb_rd_addr,
    input  logic                     wb_reg_write,
    input  logic                     dmem_ack,
    output logic [FORWARD_WIDTH-1:0] forward_op1,
    output logic [FORWARD_WIDTH-1:0] forward_op2,
    output logic                     stall_pc,
    output logic                     stall_if_id,
    output logic                     bubble_id_ex,
    output logic                     flush_if_id,
    output logic                     pc_redirect,
    output logic                     freeze,
    output logic [31:0]              stall_cnt,
    output logic [31:0]              flush_cnt,
    output hz_state_t                state_dbg
);

    hz_state_t                state;
    hz_state_t                state_next;
    logic [FORWARD_WIDTH-1:0] fwd1_raw;
    logic [FORWARD_WIDTH-1:0] fwd2_raw;
    logic                     rs1_used;
    logic                     rs2_used;
    logic                     load_use_hz;
    logic                     branch_ex_hz;
    logic                     branch_load_hz;
    logic                     hz;
    logic                     mem_access;
    logic                     frozen;

    fwd_sel u_fwd_op1 (
        .rs_addr      (id_rs1_addr),
        .mem_rd_addr  (mem_rd_addr),
        .mem_reg_write(mem_reg_write),
        .mem_mem_read (mem_mem_read),
        .wb_rd_addr   (wb_rd_addr),
        .wb_reg_write (wb_reg_write),
        .fwd          (fwd1_raw)
    );

    fwd_sel u_fwd_op2 (
        .rs_addr      (id_rs2_addr),
        .mem_rd_addr  (mem_rd_addr),
        .mem_reg_write(mem_reg_write),
        .mem_mem_read (mem_mem_read),
        .wb_rd_addr   (wb_rd_addr),
        .wb_reg_write (wb_reg_write),
        .fwd          (fwd2_raw)
    );

    assign forward_op1 = rst ? FORWARD_NONE : fwd1_raw;
    assign forward_op2 = rst ? FORWARD_NONE : fwd2_raw;

    assign rs1_used = id_rs1_rd_en && (id_rs1_addr != 5'd0);
    assign rs2_used = id_rs2_rd_en && (id_rs2_addr != 5'd0);

    function automatic logic reads_reg(input logic [4:0] rd);
        return (rs1_used && addr_hit(rd, id_rs1_addr)) ||
               (rs2_used && addr_hit(rd, id_rs2_addr));
    endfunction

    assign load_use_hz    = ex_mem_read && ex_reg_write && reads_reg(ex_rd_addr);
    assign branch_ex_hz   = id_is_branch && ex_reg_write && reads_reg(ex_rd_addr);
    assign branch_load_hz = id_is_branch && mem_mem_read && mem_reg_write &&
                            reads_reg(mem_rd_addr);
    assign hz             = load_use_hz || branch_ex_hz || branch_load_hz;

    // Freeze starts in the first MEM cycle of an unacked access and ends
    // combinationally in the ack cycle, so an ack on arrival never freezes.
    assign mem_access = mem_mem_read || mem_mem_write;
    assign frozen     = !dmem_ack && ((state == MEM_WAIT) || mem_access);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:      if (mem_access && !dmem_ack) state_next = MEM_WAIT;
            MEM_WAIT: if (dmem_ack) state_next = RUN;
            default:  state_next = RUN;
        endcase
    end

    // Priority: reset, then memory freeze, then hazard bubble, then redirect.
    always_comb begin
        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        bubble_id_ex = 1'b0;
        flush_if_id  = 1'b0;
        pc_redirect  = 1'b0;
        freeze       = 1'b0;
        if (!rst) begin
            if (frozen) begin
                freeze      = 1'b1;
                stall_pc    = 1'b1;
                stall_if_id = 1'b1;
            end else if (hz) begin
                stall_pc     = 1'b1;
                stall_if_id  = 1'b1;
                bubble_id_ex = 1'b1;
            end else if (id_is_branch && id_branch_taken) begin
                pc_redirect = 1'b1;
                flush_if_id = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            stall_cnt <= stall_cnt + 32'(stall_pc);
            flush_cnt <= flush_cnt + 32'(flush_if_id);
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline scenarios plus randomized
// cycles, all checked against a rule-level reference model.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    typedef struct {
        logic       rst;
        logic       rs1_en, rs2_en;
        logic [4:0] rs1, rs2;
        logic       br, taken;
        logic [4:0] ex_rd;
        logic       ex_rw, ex_mr;
        logic [4:0] mem_rd;
        logic       mem_rw, mem_mr, mem_mw;
        logic [4:0] wb_rd;
        logic       wb_rw;
        logic       ack;
    } in_t;

    typedef struct {
        logic       stall, bubble, flush, freeze;
        logic [1:0] fwd1, fwd2;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     id_rs1_rd_en, id_rs2_rd_en;
    logic [4:0]               id_rs1_addr, id_rs2_addr;
    logic                     id_is_branch, id_branch_taken;
    logic [4:0]               ex_rd_addr;
    logic                     ex_reg_write, ex_mem_read;
    logic [4:0]               mem_rd_addr;
    logic                     mem_reg_write, mem_mem_read, mem_mem_write;
    logic [4:0]               wb_rd_addr;
    logic                     wb_reg_write;
    logic                     dmem_ack;
    logic [FORWARD_WIDTH-1:0] forward_op1, forward_op2;
    logic                     stall_pc, stall_if_id, bubble_id_ex;
    logic                     flush_if_id, pc_redirect, freeze;
    logic [31:0]              stall_cnt, flush_cnt;
    hz_state_t                state_dbg;

    int          checks = 0;
    int          errors = 0;
    logic        m_wait = 1'b0;
    logic [31:0] m_stall = 32'd0;
    logic [31:0] m_flush = 32'd0;
    logic [63:0] exp_q[$];

    hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .id_rs1_rd_en(id_rs1_rd_en), .id_rs2_rd_en(id_rs2_rd_en),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_is_branch(id_is_branch), .id_branch_taken(id_branch_taken),
        .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write),
        .dmem_ack(dmem_ack),
        .forward_op1(forward_op1), .forward_op2(forward_op2),
        .stall_pc(stall_pc), .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex),
        .flush_if_id(flush_if_id), .pc_redirect(pc_redirect), .freeze(freeze),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic in_t idle();
        in_t v;
        v = '{default: '0};
        v.ack = 1'b1;
        return v;
    endfunction

    function automatic logic [1:0] fwd_of(input in_t v, input logic [4:0] rs);
        if (rs == 5'd0) return FORWARD_NONE;
        if (v.mem_rw && !v.mem_mr && v.mem_rd == rs) return FORWARD_MEM;
        if (v.wb_rw && v.wb_rd == rs) return FORWARD_WB;
        return FORWARD_NONE;
    endfunction

    // Reference model: expected control outputs from the pipeline rules.
    function automatic exp_t model_outputs(input in_t v, input logic waiting);
        exp_t       e;
        logic [4:0] srcs[$];
        logic       hz;
        e = '{default: '0};
        e.fwd1 = FORWARD_NONE;
        e.fwd2 = FORWARD_NONE;
        if (v.rst) return e;
        e.fwd1 = fwd_of(v, v.rs1);
        e.fwd2 = fwd_of(v, v.rs2);
        if (v.rs1_en && v.rs1 != 5'd0) srcs.push_back(v.rs1);
        if (v.rs2_en && v.rs2 != 5'd0) srcs.push_back(v.rs2);
        hz = 1'b0;
        foreach (srcs[i]) begin
            if (v.ex_mr && v.ex_rw && v.ex_rd == srcs[i]) hz = 1'b1;
            if (v.br && v.ex_rw && v.ex_rd == srcs[i]) hz = 1'b1;
            if (v.br && v.mem_mr && v.mem_rw && v.mem_rd == srcs[i]) hz = 1'b1;
        end
        if ((waiting || v.mem_mr || v.mem_mw) && !v.ack) begin
            e.freeze = 1'b1;
            e.stall  = 1'b1;
        end else if (hz) begin
            e.stall  = 1'b1;
            e.bubble = 1'b1;
        end else if (v.br && v.taken) begin
            e.flush = 1'b1;
        end
        return e;
    endfunction

    task automatic drive(input in_t v);
        rst = v.rst;
        id_rs1_rd_en = v.rs1_en;  id_rs2_rd_en = v.rs2_en;
        id_rs1_addr = v.rs1;      id_rs2_addr = v.rs2;
        id_is_branch = v.br;      id_branch_taken = v.taken;
        ex_rd_addr = v.ex_rd;     ex_reg_write = v.ex_rw;   ex_mem_read = v.ex_mr;
        mem_rd_addr = v.mem_rd;   mem_reg_write = v.mem_rw;
        mem_mem_read = v.mem_mr;  mem_mem_write = v.mem_mw;
        wb_rd_addr = v.wb_rd;     wb_reg_write = v.wb_rw;
        dmem_ack = v.ack;
    endtask

    // One pipeline cycle: drive at negedge, check before the next posedge.
    task automatic step(input in_t v);
        exp_t e;
        @(negedge clk);
        drive(v);
        #1;
        e = model_outputs(v, m_wait);
        check("stall_pc", stall_pc, e.stall);
        check("stall_if_id", stall_if_id, e.stall);
        check("bubble_id_ex", bubble_id_ex, e.bubble);
        check("flush_if_id", flush_if_id, e.flush);
        check("pc_redirect", pc_redirect, e.flush);
        check("freeze", freeze, e.freeze);
        check("forward_op1", forward_op1, e.fwd1);
        check("forward_op2", forward_op2, e.fwd2);
        check("state", state_dbg, m_wait ? MEM_WAIT : RUN);
        if (exp_q.size() > 0) check("counters", {flush_cnt, stall_cnt}, exp_q.pop_front());
        if (v.rst) begin
            m_wait  = 1'b0;
            m_stall = 32'd0;
            m_flush = 32'd0;
        end else begin
            m_wait  = e.freeze;
            m_stall = m_stall + 32'(e.stall);
            m_flush = m_flush + 32'(e.flush);
        end
        exp_q.push_back({m_flush, m_stall});
    endtask

    task automatic do_reset();
        in_t v;
        v = idle();
        v.rst = 1'b1;
        step(v);
    endtask

    function automatic in_t rand_in();
        in_t v;
        v.rst    = ($urandom_range(0, 49) == 0);
        v.rs1_en = 1'($urandom_range(0, 1));
        v.rs2_en = 1'($urandom_range(0, 1));
        v.rs1    = 5'($urandom_range(0, 3));
        v.rs2    = 5'($urandom_range(0, 3));
        v.br     = ($urandom_range(0, 2) == 0);
        v.taken  = 1'($urandom_range(0, 1));
        v.ex_rd  = 5'($urandom_range(0, 3));
        v.ex_rw  = 1'($urandom_range(0, 1));
        v.ex_mr  = 1'($urandom_range(0, 1));
        v.mem_rd = 5'($urandom_range(0, 3));
        v.mem_rw = 1'($urandom_range(0, 1));
        v.mem_mr = ($urandom_range(0, 3) == 0);
        v.mem_mw = ($urandom_range(0, 3) == 0);
        v.wb_rd  = 5'($urandom_range(0, 3));
        v.wb_rw  = 1'($urandom_range(0, 1));
        v.ack    = 1'($urandom_range(0, 1));
        return v;
    endfunction

    initial begin
        in_t v;
        drive(idle());
        rst = 1'b1;
        do_reset();
        do_reset();
        step(idle());
        check("reset_state", state_dbg, RUN);
        check("reset_stall_cnt", stall_cnt, 32'd0);

        // Load-use: lw x5 in EX, consumer of x5 in ID.
        do_reset();
        v = idle();
        v.ex_mr = 1; v.ex_rw = 1; v.ex_rd = 5; v.rs1_en = 1; v.rs1 = 5;
        step(v);
        check("lu_stall", {stall_pc, stall_if_id, bubble_id_ex}, 3'b111);
        v = idle();
        v.wb_rw = 1; v.wb_rd = 5; v.rs1_en = 1; v.rs1 = 5;
        step(v);
        check("lu_fwd_wb", forward_op1, FORWARD_WB);
        check("lu_no_stall", stall_pc, 1'b0);
        step(idle());
        check("lu_stall_cnt", stall_cnt, 32'd1);

        // Load feeding a taken branch: two stalls, then redirect.
        do_reset();
        v = idle();
        v.ex_mr = 1; v.ex_rw = 1; v.ex_rd = 7;
        v.rs1_en = 1; v.rs1 = 7; v.rs2_en = 1; v.rs2 = 0; v.br = 1; v.taken = 1;
        step(v);
        check("lb_stall1", stall_pc, 1'b1);
        check("lb_no_redirect1", pc_redirect, 1'b0);
        v.ex_mr = 0; v.ex_rw = 0; v.ex_rd = 0;
        v.mem_mr = 1; v.mem_rw = 1; v.mem_rd = 7; v.ack = 1;
        step(v);
        check("lb_stall2", stall_pc, 1'b1);
        v.mem_mr = 0; v.mem_rw = 0; v.mem_rd = 0; v.wb_rw = 1; v.wb_rd = 7;
        step(v);
        check("lb_redirect", {pc_redirect, flush_if_id, stall_pc}, 3'b110);
        step(idle());
        check("lb_stall_cnt", stall_cnt, 32'd2);
        check("lb_flush_cnt", flush_cnt, 32'd1);

        // Forwarding priority and x0.
        v = idle();
        v.mem_rw = 1; v.mem_rd = 3; v.wb_rw = 1; v.wb_rd = 3; v.rs2_en = 1; v.rs2 = 3;
        step(v);
        check("fwd_mem_prio", forward_op2, FORWARD_MEM);
        v.mem_mr = 1;
        step(v);
        check("fwd_load_in_mem", forward_op2, FORWARD_WB);
        v = idle();
        v.mem_rw = 1; v.wb_rw = 1; v.ex_rw = 1; v.rs1_en = 1; v.rs2_en = 1;
        step(v);
        check("fwd_x0_op1", forward_op1, FORWARD_NONE);
        check("fwd_x0_op2", forward_op2, FORWARD_NONE);

        // Slow store with a pending load-use in ID.
        do_reset();
        v = idle();
        v.mem_mw = 1; v.ack = 0;
        v.ex_mr = 1; v.ex_rw = 1; v.ex_rd = 9; v.rs1_en = 1; v.rs1 = 9;
        for (int i = 0; i < 3; i++) begin
            step(v);
            check("slow_freeze", {freeze, stall_pc, bubble_id_ex}, 3'b110);
        end
        check("slow_state", state_dbg, MEM_WAIT);
        v.ack = 1;
        step(v);
        check("slow_ack", {freeze, stall_pc, bubble_id_ex}, 3'b011);
        step(idle());
        check("slow_stall_cnt", stall_cnt, 32'd4);

        // Reset while waiting on memory.
        v = idle();
        v.mem_mr = 1; v.ack = 0;
        step(v);
        step(v);
        check("rw_waiting", state_dbg, MEM_WAIT);
        v.rst = 1; v.br = 1; v.taken = 1;
        v.ex_mr = 1; v.ex_rw = 1; v.ex_rd = 2; v.rs1_en = 1; v.rs1 = 2;
        v.wb_rw = 1; v.wb_rd = 2;
        step(v);
        check("rw_outputs", {freeze, stall_pc, stall_if_id, bubble_id_ex,
                             flush_if_id, pc_redirect, forward_op1}, 8'd0);
        step(idle());
        check("rw_state", state_dbg, RUN);
        check("rw_counters", {flush_cnt, stall_cnt}, 64'd0);

        // Stall counter wrap.
        @(negedge clk);
        force dut.stall_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt;
        m_stall = 32'hFFFF_FFFF;
        exp_q.delete();
        exp_q.push_back({m_flush, m_stall});
        v = idle();
        v.ex_mr = 1; v.ex_rw = 1; v.ex_rd = 4; v.rs2_en = 1; v.rs2 = 4;
        step(v);
        check("wrap_pre", stall_cnt, 32'hFFFF_FFFF);
        step(idle());
        check("wrap_zero", stall_cnt, 32'd0);

        // Randomized cycles against the model.
        for (int i = 0; i < 3000; i++) begin
            step(rand_in());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
